jtgng_objdma_ctrl: RTL and testbench

- Object-RAM DMA controller, directly upstream of the dual-clock object buffer RAM: on a frame trigger it requests the CPU bus and copies the CPU-side object table into the buffer's write port, one byte per clock-enable cycle.
- Runs in the CPU/video clock domain.
- Sits between the CPU bus arbiter (BR/BA handshake), the CPU work RAM read port and the buffer write port.

---
 rtl/jtgng_objdma_ctrl.sv | 175 +++++++++++++++++
 tb/tb_jtgng_objdma_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_objdma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jtgng_objdma_ctrl
// Purpose  : Object-RAM DMA controller. On a frame trigger it requests the
//            CPU bus and, once granted, copies 2**AW bytes from the CPU work
//            RAM into the object buffer write port, one byte per cen cycle,
//            in ascending address order.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       system clock (CPU/video domain)
//   rst_n     asynchronous active-low reset
//   cen       clock enable; state advances only on enabled edges
//   dma_trig  start request, accepted only while idle
//   bus_ack   CPU bus grant (BA/BS decoded)
//   bus_req   CPU bus request (BR)
//   src_addr  work RAM read address
//   src_din   work RAM read data, one cen cycle behind src_addr
//   buf_addr  object buffer write address
//   buf_dout  object buffer write data
//   buf_we    object buffer write enable
//   busy      transfer in progress
//   done      one-cen-cycle end-of-transfer pulse
// ============================================================================
module jtgng_objdma_ctrl #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          dma_trig,
    input  logic          bus_ack,
    output logic          bus_req,
    output logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_din,
    output logic [AW-1:0] buf_addr,
    output logic [DW-1:0] buf_dout,
    output logic          buf_we,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_copy = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [AW-1:0] c_last = {AW{1'b1}};

    logic [1:0]    r_state,    w_state;
    logic          r_bus_req,  w_bus_req;
    logic [AW-1:0] r_src_addr, w_src_addr;
    logic [AW-1:0] r_buf_addr, w_buf_addr;
    logic [DW-1:0] r_buf_dout, w_buf_dout;
    logic          r_buf_we,   w_buf_we;
    logic          r_busy,     w_busy;
    logic          r_done,     w_done;
    // r_pend: a read was issued last cycle, so src_din now holds the byte
    // for r_rd_addr. r_wrote: at least one byte of this transfer is written.
    logic          r_pend,     w_pend;
    logic [AW-1:0] r_rd_addr,  w_rd_addr;
    logic          r_wrote,    w_wrote;

    always_comb begin
        w_state    = r_state;
        w_bus_req  = r_bus_req;
        w_src_addr = r_src_addr;
        w_buf_addr = r_buf_addr;
        w_buf_dout = r_buf_dout;
        w_buf_we   = r_buf_we;
        w_busy     = r_busy;
        w_done     = r_done;
        w_pend     = r_pend;
        w_rd_addr  = r_rd_addr;
        w_wrote    = r_wrote;

        case (r_state)
            c_st_idle: begin
                w_done = 1'b0;
                if (dma_trig) begin
                    w_state    = c_st_req;
                    w_bus_req  = 1'b1;
                    w_busy     = 1'b1;
                    w_src_addr = '0;
                    w_buf_addr = '0;
                    w_buf_we   = 1'b0;
                    w_pend     = 1'b0;
                    w_wrote    = 1'b0;
                end
            end
            c_st_req: begin
                if (bus_ack) begin
                    w_state = c_st_copy;
                end
            end
            c_st_copy: begin
                if (bus_ack) begin
                    w_buf_we = r_pend;
                    if (r_pend) begin
                        w_buf_dout = src_din;
                        w_buf_addr = r_rd_addr;
                        w_wrote    = 1'b1;
                    end
                    if (r_pend && (r_rd_addr == c_last)) begin
                        w_state = c_st_done;
                        w_pend  = 1'b0;
                    end else begin
                        // The address stalls at the top so the final byte
                        // is still presented while its data comes back.
                        if (r_src_addr != c_last) begin
                            w_src_addr = r_src_addr + AW'(1);
                        end
                        w_rd_addr = r_src_addr;
                        w_pend    = 1'b1;
                    end
                end else begin
                    // Bus lost: drop the in-flight read and rewind so it is
                    // fetched again once the grant returns.
                    w_buf_we   = 1'b0;
                    w_pend     = 1'b0;
                    w_src_addr = r_wrote ? (r_buf_addr + AW'(1)) : '0;
                end
            end
            c_st_done: begin
                w_buf_we  = 1'b0;
                w_bus_req = 1'b0;
                w_busy    = 1'b0;
                w_done    = 1'b1;
                w_state   = c_st_idle;
            end
            default: begin
                w_state = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_bus_req  <= 1'b0;
            r_src_addr <= '0;
            r_buf_addr <= '0;
            r_buf_dout <= '0;
            r_buf_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pend     <= 1'b0;
            r_rd_addr  <= '0;
            r_wrote    <= 1'b0;
        end else if (cen) begin
            r_state    <= w_state;
            r_bus_req  <= w_bus_req;
            r_src_addr <= w_src_addr;
            r_buf_addr <= w_buf_addr;
            r_buf_dout <= w_buf_dout;
            r_buf_we   <= w_buf_we;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_pend     <= w_pend;
            r_rd_addr  <= w_rd_addr;
            r_wrote    <= w_wrote;
        end
    end

    assign bus_req  = r_bus_req;
    assign src_addr = r_src_addr;
    assign buf_addr = r_buf_addr;
    assign buf_dout = r_buf_dout;
    assign buf_we   = r_buf_we;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_jtgng_objdma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtgng_objdma_ctrl
// Purpose  : Self-checking bench for jtgng_objdma_ctrl (AW=4). A registered
//            1-cycle work RAM is modelled in the stepping task; a scoreboard
//            expects every address 0..15 written once, ascending, with the
//            RAM contents, and never while the bus grant was low.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtgng_objdma_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cen;
    logic          dma_trig;
    logic          bus_ack;
    logic          bus_req;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_din;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_dout;
    logic          buf_we;
    logic          busy;
    logic          done;

    jtgng_objdma_ctrl #(.AW(AW), .DW(DW)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .dma_trig (dma_trig),
        .bus_ack  (bus_ack),
        .bus_req  (bus_req),
        .src_addr (src_addr),
        .src_din  (src_din),
        .buf_addr (buf_addr),
        .buf_dout (buf_dout),
        .buf_we   (buf_we),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_bad   = 0;
    int         div     = 1;
    int         clk_cnt = 0;
    int         wr_idx  = 0;
    int         done_cnt = 0;
    bit         last_we_final = 1'b0;
    logic [7:0] mem [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One enabled clock edge, preceded by div-1 disabled edges.
    task automatic step();
        logic [63:0]   snap;
        logic [AW-1:0] a;
        logic          ack_at_edge;
        for (int i = 0; i < div - 1; i++) begin
            cen  = 1'b0;
            snap = {bus_req, busy, buf_we, done, src_addr, buf_addr, buf_dout};
            @(posedge clk); #1;
            clk_cnt++;
            check("hold_no_cen", {bus_req, busy, buf_we, done, src_addr, buf_addr, buf_dout}, snap);
        end
        a           = src_addr;
        ack_at_edge = bus_ack;
        cen = 1'b1;
        @(posedge clk); #1;
        clk_cnt++;
        cen = 1'b0;
        src_din = mem[a];
        if (buf_we) begin
            check("we_with_ack", ack_at_edge, 1);
            if (wr_idx < N) begin
                check("wr_addr", buf_addr, wr_idx);
                check("wr_data", buf_dout, mem[wr_idx]);
            end else begin
                check("wr_extra", wr_idx, N - 1);
            end
            wr_idx++;
        end
        if (done) begin
            done_cnt++;
            check("done_busreq", bus_req, 0);
            check("done_busy", busy, 0);
            check("done_nwr", wr_idx, N);
            check("done_after_last", last_we_final, 1);
        end
        last_we_final = buf_we && (buf_addr == AW'(N - 1));
    endtask

    task automatic fill_a5();
        for (int i = 0; i < N; i++) mem[i] = 8'(i) ^ 8'hA5;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    endtask

    task automatic run_xfer(input int ack_delay, input bit pre_ack, input int pause_at,
                            input int pause_len, input bit rand_ack, input bit retrig,
                            output int clks);
        int pause_left = 0;
        int guard      = 0;
        int clk0;
        bit paused     = 1'b0;
        wr_idx = 0;
        done_cnt = 0;
        last_we_final = 1'b0;
        bus_ack  = pre_ack;
        dma_trig = 1'b1;
        clk0 = clk_cnt;
        step();
        dma_trig = 1'b0;
        check("req_after_trig", bus_req, 1);
        check("busy_after_trig", busy, 1);
        check("src0_after_trig", src_addr, 0);
        if (!pre_ack) begin
            for (int i = 1; i < ack_delay; i++) step();
        end
        while (done_cnt == 0 && guard < 500) begin
            guard++;
            if (pause_left > 0) begin
                bus_ack = 1'b0;
                pause_left--;
            end else if (rand_ack) begin
                bus_ack = ($urandom_range(0, 3) != 0);
            end else begin
                bus_ack = 1'b1;
            end
            dma_trig = retrig && (wr_idx == 5 || wr_idx == N);
            step();
            dma_trig = 1'b0;
            if (!paused && pause_at >= 0 && wr_idx == pause_at + 1) begin
                pause_left = pause_len;
                paused = 1'b1;
            end
        end
        check("done_seen", done_cnt, 1);
        clks = clk_cnt - clk0;
        bus_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_done_low", done, 0);
            check("post_busy", busy, 0);
            check("post_req", bus_req, 0);
        end
        check("single_done", done_cnt, 1);
        check("total_writes", wr_idx, N);
    endtask

    initial begin
        int clks1, clks4, clks, g;
        rst_n    = 1'b0;
        cen      = 1'b0;
        dma_trig = 1'b0;
        bus_ack  = 1'b0;
        src_din  = '0;
        fill_a5();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {bus_req, busy, buf_we, done, src_addr, buf_addr, buf_dout}, 0);
        rst_n = 1'b1;
        repeat (2) step();
        check("idle_quiet", {bus_req, busy, buf_we, done}, 0);

        // Basic transfer, grant three cen cycles after the trigger.
        div = 1;
        run_xfer(3, 1'b0, -1, 0, 1'b0, 1'b0, clks1);

        // Grant dropped for four cycles after the write of address 6.
        run_xfer(3, 1'b0, 6, 4, 1'b0, 1'b0, clks);

        // Slow clock enable: same behaviour, four times the clocks.
        div = 4;
        run_xfer(3, 1'b0, -1, 0, 1'b0, 1'b0, clks4);
        check("clk_x4", clks4, 4 * clks1);
        div = 1;

        // Re-triggers mid-transfer and on the done edge are dropped.
        run_xfer(3, 1'b0, -1, 0, 1'b0, 1'b1, clks);

        // Asynchronous reset in the middle of a transfer.
        wr_idx = 0;
        done_cnt = 0;
        last_we_final = 1'b0;
        bus_ack  = 1'b0;
        dma_trig = 1'b1;
        step();
        dma_trig = 1'b0;
        bus_ack  = 1'b1;
        g = 0;
        while (wr_idx < 10 && g < 100) begin
            g++;
            step();
        end
        check("rst_reached_w9", wr_idx, 10);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {bus_req, busy, buf_we, done, src_addr, buf_addr, buf_dout}, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        bus_ack = 1'b0;
        run_xfer(2, 1'b0, -1, 0, 1'b0, 1'b0, clks);

        // Randomised data, grant pattern and clock-enable ratio.
        for (int r = 0; r < 5; r++) begin
            div = $urandom_range(1, 3);
            fill_rand();
            run_xfer($urandom_range(1, 5), 1'($urandom_range(0, 1)), -1, 0, 1'b1, 1'b0, clks);
        end
        div = 1;

        // Grant never arrives: request held forever, nothing written.
        wr_idx = 0;
        bus_ack  = 1'b0;
        dma_trig = 1'b1;
        step();
        dma_trig = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            check("no_ack_hold", {bus_req, busy, buf_we}, 3'b110);
        end
        check("no_ack_nwr", wr_idx, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
